seven_scan: RTL and testbench
=============================

SEVEN_SCAN -- requirements
Module: seven_scan

Interface
REQ-001 Parameter: PRESCALE, default 1000, clk cycles per digit slot; legal range 2..65535.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  display word offered.
REQ-005 Port: in_ready  output  1  block can accept a display word.
REQ-006 Port: din  input  16  four BCD nibbles; digit0 = din[3:0] (rightmost), digit3 = din[15:12].
REQ-007 Port: blank_lz  input  1  suppress leading zeros when high.
REQ-008 Port: bcd  output  4  nibble of the currently scanned digit, drives seven decoder inputs a,b,c,d (a = bcd[3], d = bcd[0]).
REQ-009 Port: an  output  4  active-low digit enables; exactly one bit low, or all high when blanked.

Function
REQ-010 Prescaler cnt counts 0..PRESCALE-1 and wraps; tick asserted in the cycle cnt == PRESCALE-1.
REQ-011 Digit index idx (2 bits) increments on tick, 3 -> 0 wrap; frame boundary = tick with idx == 3.
REQ-012 bcd = disp nibble idx; an = ~(1 << idx); both decoded combinationally from registered idx, disp and blank_lz.
REQ-013 Each digit is therefore enabled for exactly PRESCALE cycles; full frame = 4*PRESCALE cycles.
REQ-014 Handshake: transfer occurs in a cycle with in_valid && in_ready; din sampled at that edge.
REQ-015 A transfer outside a frame boundary writes the pending register pend and sets pend_full; in_ready is low while pend_full.
REQ-016 At a frame boundary with pend_full: disp <= pend, pend_full cleared, in_ready high next cycle.
REQ-017 At a frame boundary with pend_full low and a simultaneous transfer: din loads disp directly; pend_full stays low.
REQ-018 Display contents never change mid-frame (no tearing); latency from transfer to display = until next frame boundary.
REQ-019 Leading-zero blanking: when blank_lz high, digit k (k = 1..3) drives an = 4'b1111 if nibbles k..3 of disp are all zero; digit 0 never blanked.
REQ-020 Nibbles 10..15 pass to bcd unchanged; decoding is the downstream decoder's concern.
REQ-021 in_valid with in_ready low has no effect; source must hold din and in_valid until accepted.

Reset
REQ-022 While rst high: cnt = 0, idx = 0, disp = 16'h0000, pend_full = 0, in_ready = 1.
REQ-023 Resulting outputs during and after reset: bcd = 4'h0, an = 4'b1110.
REQ-024 Reset mid-frame or with pend_full discards pending word; first tick after release occurs PRESCALE cycles later.

Structure
REQ-025 Shared package seven_pkg holds NDIG = 4, DIG_W = 4, AN_OFF = 4'b1111, and the display-word width constant.
REQ-026 One sub-module: seven_tick (parameterised PRESCALE prescaler producing tick); handshake, pend/disp and idx logic stay in seven_scan.

Verification (PRESCALE = 4)
REQ-027 Reset release, no input -> an cycles 1110,1101,1011,0111 each for 4 cycles, bcd = 0 throughout.
REQ-028 Transfer din = 16'h1234 at cycle 2 of frame, blank_lz = 0 -> in_ready low until next boundary; next frame digit0..3 show bcd 4,3,2,1.
REQ-029 disp = 16'h0050, blank_lz = 1 -> digit0 bcd 0 an 1110, digit1 bcd 5 an 1101, digits 2,3 an 1111.
REQ-030 Transfer coinciding exactly with frame boundary, pend empty, din = 16'h9876 -> shown starting next cycle (digit0 bcd 6), in_ready stays high.
REQ-031 Second in_valid while pend_full -> ignored; first word displayed at boundary, second accepted afterwards and shown one frame later.
REQ-032 rst asserted mid-frame with pend_full -> immediate an = 1110, bcd = 0, in_ready = 1; pending word never displayed.

Source files
------------

// File: rtl/seven_pkg.sv
// Shared constants and helpers for the four-digit multiplexed BCD display scanner.
// The display word is NDIG nibbles wide, digit0 in the least-significant nibble.
package seven_pkg;

  localparam int NDIG   = 4;
  localparam int DIG_W  = 4;
  localparam int WORD_W = NDIG * DIG_W;

  localparam logic [NDIG-1:0] AN_OFF = '1;

  // True when every nibble from position k up to the top digit is zero.
  function automatic logic upper_zero(input logic [WORD_W-1:0] word, input logic [1:0] k);
    logic zero;
    zero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= int'(k) && word[i*DIG_W +: DIG_W] != '0) begin
        zero = 1'b0;
      end
    end
    return zero;
  endfunction

endpackage

// File: rtl/seven_tick.sv
// Free-running prescaler: counts 0..PRESCALE-1 and flags the last count as tick.
// Every digit slot of the scanner lasts exactly one full prescaler period.
module seven_tick #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/seven_scan.sv
// Four-digit multiplexed BCD display scanner with a one-deep pending word so that
// new display contents only take effect at a frame boundary.
module seven_scan
  import seven_pkg::*;
#(
  parameter int PRESCALE = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] din,
  input  logic              blank_lz,
  output logic [DIG_W-1:0]  bcd,
  output logic [NDIG-1:0]   an
);

  logic              tick;
  logic [1:0]        idx;
  logic [WORD_W-1:0] disp;
  logic [WORD_W-1:0] pend;
  logic              pend_full;
  logic              frame_end;
  logic              xfer;

  seven_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame_end = tick && (idx == 2'd3);
  assign in_ready  = ~pend_full;
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // A word arriving exactly on the boundary bypasses pend; otherwise it waits there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (frame_end) begin
      if (pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (xfer) begin
        disp <= din;
      end
    end else if (xfer) begin
      pend      <= din;
      pend_full <= 1'b1;
    end
  end

  always_comb begin
    bcd = disp[DIG_W*idx +: DIG_W];
    an  = ~(NDIG'(1) << idx);
    if (blank_lz && idx != 2'd0 && upper_zero(disp, idx)) begin
      an = AN_OFF;
    end
  end

endmodule

// File: tb/tb_seven_scan.sv
// Self-checking bench for seven_scan at PRESCALE = 4: hand sequences, a vector table
// and randomized traffic, all compared against a frame-level reference model.
module tb_seven_scan;
  import seven_pkg::*;

  localparam int P     = 4;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  // Reference model: edges since reset release, shown word and pending words.
  int          c;
  logic [15:0] m_disp;
  logic [15:0] m_pend[$];
  logic        cur_blz;

  typedef struct packed {
    logic [15:0] word;
    logic        blz;
    logic [15:0] e_bcd;
    logic [15:0] e_an;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  seven_scan #(.PRESCALE(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .blank_lz (blank_lz),
    .bcd      (bcd),
    .an       (an)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_idx();
    return (c / P) % 4;
  endfunction

  function automatic logic [3:0] model_bcd();
    logic [15:0] shifted;
    shifted = m_disp >> (4 * model_idx());
    return shifted[3:0];
  endfunction

  function automatic logic [3:0] model_an(input logic blz);
    logic [15:0] shifted;
    int          k;
    k       = model_idx();
    shifted = m_disp >> (4 * k);
    if (blz && k != 0 && shifted == 16'h0) return 4'b1111;
    return ~(4'b0001 << k);
  endfunction

  // Called at a falling edge: drives inputs, checks outputs, advances model over next rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic b, output logic acc);
    logic ready_m;
    in_valid = v;
    din      = d;
    blank_lz = b;
    #1;
    ready_m = (m_pend.size() == 0);
    checkOutput("bcd", {12'h0, bcd}, {12'h0, model_bcd()});
    checkOutput("an", {12'h0, an}, {12'h0, model_an(b)});
    checkOutput("in_ready", {15'h0, in_ready}, {15'h0, ready_m});
    acc = v && ready_m;
    if ((c + 1) % FRAME == 0) begin
      if (m_pend.size() > 0) m_disp = m_pend.pop_front();
      else if (acc) m_disp = d;
    end else if (acc) begin
      m_pend.push_back(d);
    end
    c++;
    @(negedge clk);
  endtask

  task automatic idle();
    logic acc;
    applyStimulus(1'b0, 16'h0, cur_blz, acc);
  endtask

  task automatic runTo(input int phase);
    while (c % FRAME != phase) idle();
  endtask

  task automatic sendWord(input logic [15:0] w);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 4 * FRAME) begin
      applyStimulus(1'b1, w, cur_blz, acc);
      n++;
    end
    in_valid = 1'b0;
    checkOutput("accepted", {15'h0, acc}, 16'h0001);
  endtask

  // Entered at a falling edge; checks the outputs while reset is held.
  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_an", {12'h0, an}, 16'h000E);
    checkOutput("rst_bcd", {12'h0, bcd}, 16'h0000);
    checkOutput("rst_ready", {15'h0, in_ready}, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_disp = 16'h0;
    m_pend.delete();
    c      = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] an_seq;
    logic [15:0] eb;
    logic [15:0] ea;
    logic        acc;

    vecs[0] = '{word: 16'h1234, blz: 1'b0, e_bcd: 16'h1234, e_an: 16'h7BDE};
    vecs[1] = '{word: 16'h0050, blz: 1'b1, e_bcd: 16'h0050, e_an: 16'hFFDE};
    vecs[2] = '{word: 16'h0000, blz: 1'b1, e_bcd: 16'h0000, e_an: 16'hFFFE};
    vecs[3] = '{word: 16'hF00A, blz: 1'b1, e_bcd: 16'hF00A, e_an: 16'h7BDE};
    vecs[4] = '{word: 16'h0300, blz: 1'b1, e_bcd: 16'h0300, e_an: 16'hFBDE};
    vecs[5] = '{word: 16'h0050, blz: 1'b0, e_bcd: 16'h0050, e_an: 16'h7BDE};
    vecs[6] = '{word: 16'h000C, blz: 1'b1, e_bcd: 16'h000C, e_an: 16'hFFFE};

    rst      = 1'b1;
    in_valid = 1'b0;
    din      = 16'h0;
    blank_lz = 1'b0;
    cur_blz  = 1'b0;
    m_disp   = 16'h0;
    c        = 0;
    @(negedge clk);
    doReset();

    // Idle frame after reset: each anode in turn for P cycles, bcd stays 0.
    an_seq = 16'h7BDE;
    for (int d = 0; d < 4; d++) begin
      checkOutput("idle_an", {12'h0, an}, {12'h0, an_seq[4*d +: 4]});
      checkOutput("idle_bcd", {12'h0, bcd}, 16'h0000);
      for (int j = 0; j < P; j++) idle();
    end

    // Mid-frame transfer goes to pend and blocks in_ready until the boundary.
    runTo(2);
    applyStimulus(1'b1, 16'h1234, 1'b0, acc);
    in_valid = 1'b0;
    checkOutput("mid_ready_low", {15'h0, in_ready}, 16'h0000);
    checkOutput("mid_no_tear", {12'h0, bcd}, 16'h0000);
    runTo(0);
    checkOutput("mid_ready_back", {15'h0, in_ready}, 16'h0001);
    checkOutput("mid_shown", {12'h0, bcd}, 16'h0004);
    for (int j = 0; j < 2 * P; j++) idle();
    checkOutput("mid_digit2", {12'h0, bcd}, 16'h0002);

    // Transfer exactly on the frame boundary loads the display directly.
    runTo(FRAME - 1);
    applyStimulus(1'b1, 16'h9876, 1'b0, acc);
    in_valid = 1'b0;
    checkOutput("bnd_ready", {15'h0, in_ready}, 16'h0001);
    checkOutput("bnd_bcd", {12'h0, bcd}, 16'h0006);
    checkOutput("bnd_an", {12'h0, an}, 16'h000E);

    // Second word while pend is full waits; it is taken right after the boundary.
    runTo(5);
    sendWord(16'h1111);
    sendWord(16'h2222);
    checkOutput("second_phase", 16'(c % FRAME), 16'h0001);
    checkOutput("first_shown", {12'h0, bcd}, 16'h0001);
    runTo(0);
    checkOutput("second_shown", {12'h0, bcd}, 16'h0002);

    // Reset mid-frame with a pending word discards it.
    runTo(1);
    sendWord(16'h5555);
    runTo(7);
    doReset();
    for (int j = 0; j < 2 * FRAME; j++) idle();
    checkOutput("rst_discard", {12'h0, bcd}, 16'h0000);

    // Table of display words and the expected digit-by-digit outputs.
    foreach (vecs[i]) begin
      cur_blz = vecs[i].blz;
      eb      = vecs[i].e_bcd;
      ea      = vecs[i].e_an;
      sendWord(vecs[i].word);
      runTo(0);
      for (int d = 0; d < 4; d++) begin
        for (int j = 0; j < P; j++) begin
          checkOutput("tbl_bcd", {12'h0, bcd}, {12'h0, eb[4*d +: 4]});
          checkOutput("tbl_an", {12'h0, an}, {12'h0, ea[4*d +: 4]});
          idle();
        end
      end
    end

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) cur_blz = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), cur_blz, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
